mem_port_arbiter: RTL

- Shares the single instruction/data memory port between the fetch stage and the data-access stage.
- Grants the port to one requester at a time and holds the grant for the full burst (access_size words).
- Drives the memory's address, rw, access_size and enable, and returns per-requester stall and done signals.
- Fetch's stall input is driven directly from f_stall.

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one instruction/data memory port between the
// fetch stage and the data-access stage. The winner owns the port for a
// whole burst. Back-to-back bursts are re-arbitrated on the edge that ends
// the last beat, so no bubble cycle is inserted between them.
//
// Ports:
//   clock, reset_n            - clock and asynchronous active-low reset
//   f_req/f_addr/f_size       - fetch request (always a read)
//   f_grant/f_stall/f_done    - fetch owns port / waiting / last beat pulse
//   d_req/d_rw/d_addr/d_size  - data request (d_rw: 1 = read, 0 = write)
//   d_grant/d_stall/d_done    - data owns port / waiting / last beat pulse
//   mem_addr/mem_rw/mem_access_size/mem_enable - memory-side request, held per burst
module mem_port_arbiter #(
    parameter int unsigned MAX_BURST       = 16,
    parameter int unsigned MAX_DATA_STREAK = 2,
    parameter int unsigned WORD_BYTES      = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic [31:0] f_size,
    output logic        f_grant,
    output logic        f_stall,
    output logic        f_done,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_size,
    output logic        d_grant,
    output logic        d_stall,
    output logic        d_done,
    output logic [31:0] mem_addr,
    output logic        mem_rw,
    output logic [31:0] mem_access_size,
    output logic        mem_enable
);

    localparam int unsigned CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned STREAK_W  = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
    localparam int unsigned ALIGN_W   = $clog2(WORD_BYTES);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << ALIGN_W) - 32'd1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        F_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    // Burst length in words: 0 means 1, anything above MAX_BURST is clamped.
    function automatic logic [31:0] eff_size(input logic [31:0] size);
        if (size == 32'd0) begin
            return 32'd1;
        end else if (size > 32'(MAX_BURST)) begin
            return 32'(MAX_BURST);
        end else begin
            return size;
        end
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  f_grant_q, f_grant_d;
    logic                  d_grant_q, d_grant_d;
    logic                  f_done_q, f_done_d;
    logic                  d_done_q, d_done_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic                  mem_rw_q, mem_rw_d;
    logic [31:0]           mem_size_q, mem_size_d;
    logic                  mem_enable_q, mem_enable_d;

    logic                  arb_point;
    logic                  f_win;
    logic                  d_win;
    logic [31:0]           f_eff;
    logic [31:0]           d_eff;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            streak_q     <= '0;
            f_grant_q    <= 1'b0;
            d_grant_q    <= 1'b0;
            f_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_rw_q     <= 1'b0;
            mem_size_q   <= '0;
            mem_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            streak_q     <= streak_d;
            f_grant_q    <= f_grant_d;
            d_grant_q    <= d_grant_d;
            f_done_q     <= f_done_d;
            d_done_q     <= d_done_d;
            mem_addr_q   <= mem_addr_d;
            mem_rw_q     <= mem_rw_d;
            mem_size_q   <= mem_size_d;
            mem_enable_q <= mem_enable_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        streak_d     = streak_q;
        f_grant_d    = f_grant_q;
        d_grant_d    = d_grant_q;
        f_done_d     = 1'b0;
        d_done_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_rw_d     = mem_rw_q;
        mem_size_d   = mem_size_q;
        mem_enable_d = mem_enable_q;

        f_eff = eff_size(f_size);
        d_eff = eff_size(d_size);

        // Re-arbitrate when idle or on the edge that closes the last beat.
        arb_point = (state_q == IDLE) || (beat_q == '0);
        // Data has priority until it has won MAX_DATA_STREAK times in a row over a waiting fetch.
        f_win = f_req && (!d_req || (streak_q == STREAK_MAX));
        d_win = d_req && !f_win;

        if (arb_point) begin
            if (f_win) begin
                state_d      = F_BUSY;
                beat_d       = CNT_W'(f_eff - 32'd1);
                streak_d     = '0;
                f_grant_d    = 1'b1;
                d_grant_d    = 1'b0;
                f_done_d     = (f_eff == 32'd1);
                mem_addr_d   = f_addr & ADDR_MASK;
                mem_rw_d     = 1'b1;
                mem_size_d   = f_eff;
                mem_enable_d = 1'b1;
            end else if (d_win) begin
                state_d      = D_BUSY;
                beat_d       = CNT_W'(d_eff - 32'd1);
                if (!f_req) begin
                    streak_d = '0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
                f_grant_d    = 1'b0;
                d_grant_d    = 1'b1;
                d_done_d     = (d_eff == 32'd1);
                mem_addr_d   = d_addr & ADDR_MASK;
                mem_rw_d     = d_rw;
                mem_size_d   = d_eff;
                mem_enable_d = 1'b1;
            end else begin
                state_d      = IDLE;
                beat_d       = '0;
                f_grant_d    = 1'b0;
                d_grant_d    = 1'b0;
                mem_addr_d   = '0;
                mem_rw_d     = 1'b0;
                mem_size_d   = '0;
                mem_enable_d = 1'b0;
            end
        end else begin
            // Mid-burst: count down; the beat that reaches zero carries done.
            beat_d   = beat_q - CNT_W'(1);
            f_done_d = (state_q == F_BUSY) && (beat_q == CNT_W'(1));
            d_done_d = (state_q == D_BUSY) && (beat_q == CNT_W'(1));
        end
    end

    assign f_grant         = f_grant_q;
    assign d_grant         = d_grant_q;
    assign f_done          = f_done_q;
    assign d_done          = d_done_q;
    assign mem_addr        = mem_addr_q;
    assign mem_rw          = mem_rw_q;
    assign mem_access_size = mem_size_q;
    assign mem_enable      = mem_enable_q;

    // Stall is a pending request that does not currently own the port.
    assign f_stall = f_req & ~f_grant_q;
    assign d_stall = d_req & ~d_grant_q;

endmodule
